// File: rtl/mainmem_arbiter_if.sv
`default_nettype none
// ============================================================================
//  mainmem_arbiter_if
//  Bundles the three requester ports, loader mode, CPU hold and the main RAM
//  bus of the main-memory arbiter.
//  Revision: 1.0 - initial release
// ============================================================================
interface mainmem_arbiter_if #(
  parameter int ADDR_WIDTH = 13
);
  logic                  p0_req, p1_req, p2_req;
  logic                  p0_we, p1_we, p2_we;
  logic [ADDR_WIDTH-1:0] p0_addr, p1_addr, p2_addr;
  logic [7:0]            p0_wdata, p1_wdata, p2_wdata;
  logic                  p0_ack, p1_ack, p2_ack;
  logic [7:0]            p0_rdata, p1_rdata, p2_rdata;
  logic                  spi_load;
  logic                  cpu_hold;
  logic [ADDR_WIDTH-1:0] ram_addr;
  logic [7:0]            ram_di;
  logic                  ram_rd;
  logic                  ram_we;
  logic [7:0]            ram_do;

  // Arbiter side
  modport slave (
    input  p0_req, p1_req, p2_req, p0_we, p1_we, p2_we,
    input  p0_addr, p1_addr, p2_addr, p0_wdata, p1_wdata, p2_wdata,
    input  spi_load, ram_do,
    output p0_ack, p1_ack, p2_ack, p0_rdata, p1_rdata, p2_rdata,
    output cpu_hold, ram_addr, ram_di, ram_rd, ram_we
  );

  // Requester / RAM side
  modport master (
    output p0_req, p1_req, p2_req, p0_we, p1_we, p2_we,
    output p0_addr, p1_addr, p2_addr, p0_wdata, p1_wdata, p2_wdata,
    output spi_load, ram_do,
    input  p0_ack, p1_ack, p2_ack, p0_rdata, p1_rdata, p2_rdata,
    input  cpu_hold, ram_addr, ram_di, ram_rd, ram_we
  );
endinterface
`default_nettype wire

// File: rtl/mainmem_arbiter.sv
`default_nettype none
// ============================================================================
//  mainmem_arbiter
//  Three-port arbiter for the 8-bit main RAM: front panel (p0), SPI loader
//  (p1) and CPU (p2). Fixed priority p0 > p1 > p2 with a CPU anti-starvation
//  override and a loader-exclusive mode. One access every three cycles.
//  Revision: 1.0 - initial release
// ============================================================================
module mainmem_arbiter #(
  parameter int ADDR_WIDTH = 13,
  parameter int STARVE_MAX = 4
) (
  input  logic             clk,
  input  logic             reset,
  mainmem_arbiter_if.slave bus
);

  localparam int SW = $clog2(STARVE_MAX + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    CAPT  = 2'd2
  } state_t;

  state_t                state, state_nxt;
  logic [2:0]            req_v, elig, win_oh, ack, sel_oh;
  logic                  grant, starve_hit;
  logic                  win_we, lat_we;
  logic [ADDR_WIDTH-1:0] win_addr, lat_addr;
  logic [7:0]            win_wdata, lat_wdata;
  logic [7:0]            rdata [3];
  logic [SW-1:0]         starve_cnt;

  // A port in its ack cycle is ineligible so a held request is not served twice;
  // loader mode masks everyone except p1.
  assign req_v      = {bus.p2_req, bus.p1_req, bus.p0_req};
  assign elig       = req_v & ~ack & {~bus.spi_load, 1'b1, ~bus.spi_load};
  assign starve_hit = (starve_cnt == SW'(STARVE_MAX));

  // Next-state and winner selection; arbitration happens only in IDLE
  always_comb begin
    state_nxt = state;
    win_oh    = 3'b000;
    grant     = 1'b0;
    case (state)
      IDLE: begin
        if (elig[2] && starve_hit) win_oh = 3'b100;
        else if (elig[0])          win_oh = 3'b001;
        else if (elig[1])          win_oh = 3'b010;
        else if (elig[2])          win_oh = 3'b100;
        grant = |win_oh;
        if (grant) state_nxt = ISSUE;
      end
      ISSUE:   state_nxt = CAPT;
      CAPT:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Request field mux for the winning port
  always_comb begin
    win_we    = 1'b0;
    win_addr  = '0;
    win_wdata = 8'h00;
    if (win_oh[0]) begin
      win_we = bus.p0_we; win_addr = bus.p0_addr; win_wdata = bus.p0_wdata;
    end else if (win_oh[1]) begin
      win_we = bus.p1_we; win_addr = bus.p1_addr; win_wdata = bus.p1_wdata;
    end else if (win_oh[2]) begin
      win_we = bus.p2_we; win_addr = bus.p2_addr; win_wdata = bus.p2_wdata;
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Latch the winner's request; these also hold ram_addr/ram_di between accesses
  always_ff @(posedge clk) begin
    if (reset) begin
      sel_oh    <= 3'b000;
      lat_we    <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= 8'h00;
    end else if (grant) begin
      sel_oh    <= win_oh;
      lat_we    <= win_we;
      lat_addr  <= win_addr;
      lat_wdata <= win_wdata;
    end
  end

  // CPU starvation counter: counts p0/p1 grants while the CPU waits
  always_ff @(posedge clk) begin
    if (reset || !bus.p2_req)        starve_cnt <= '0;
    else if (grant && win_oh[2])     starve_cnt <= '0;
    else if (grant && !starve_hit)   starve_cnt <= starve_cnt + SW'(1);
  end

  // Completion: ack pulse after CAPT, read data captured only on reads
  always_ff @(posedge clk) begin
    if (reset) begin
      ack   <= 3'b000;
      rdata <= '{default: 8'h00};
    end else begin
      ack <= (state == CAPT) ? sel_oh : 3'b000;
      for (int i = 0; i < 3; i++) begin
        if (state == CAPT && !lat_we && sel_oh[i]) rdata[i] <= bus.ram_do;
      end
    end
  end

  // Strobes are gated by reset so an access aborted in ISSUE never reaches RAM
  assign bus.ram_rd   = (state == ISSUE) && !lat_we && !reset;
  assign bus.ram_we   = (state == ISSUE) &&  lat_we && !reset;
  assign bus.ram_addr = lat_addr;
  assign bus.ram_di   = lat_wdata;

  assign bus.p0_ack   = ack[0];
  assign bus.p1_ack   = ack[1];
  assign bus.p2_ack   = ack[2];
  assign bus.p0_rdata = rdata[0];
  assign bus.p1_rdata = rdata[1];
  assign bus.p2_rdata = rdata[2];
  assign bus.cpu_hold = bus.spi_load | (bus.p2_req & ~ack[2]);

endmodule
`default_nettype wire

// File: tb/tb_mainmem_arbiter.sv
`default_nettype none
// ============================================================================
//  tb_mainmem_arbiter
//  Directed self-checking bench for mainmem_arbiter with a simple RAM model.
//  Revision: 1.0 - initial release
// ============================================================================
module tb_mainmem_arbiter;

  logic clk;
  logic reset;
  int   checks;
  int   failures;

  mainmem_arbiter_if #(.ADDR_WIDTH(13)) bus ();

  mainmem_arbiter #(.ADDR_WIDTH(13), .STARVE_MAX(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  logic [7:0] mem [0:8191];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM model: read data appears the cycle after ram_rd
  always @(posedge clk) begin
    if (bus.ram_rd) bus.ram_do <= mem[bus.ram_addr];
    if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_di;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  int nc_acks;
  int p2_early;

  initial begin
    checks = 0; failures = 0;
    for (int i = 0; i < 8192; i++) mem[i] = 8'h00;
    mem[13'h0123] = 8'h5A;
    mem[13'h0010] = 8'h11;
    mem[13'h0020] = 8'h22;
    mem[13'h0030] = 8'h33;
    bus.ram_do = 8'h00;
    bus.spi_load = 1'b0;
    bus.p0_req = 0; bus.p0_we = 0; bus.p0_addr = '0; bus.p0_wdata = '0;
    bus.p1_req = 0; bus.p1_we = 0; bus.p1_addr = '0; bus.p1_wdata = '0;
    bus.p2_req = 0; bus.p2_we = 0; bus.p2_addr = '0; bus.p2_wdata = '0;
    reset = 1'b1;
    ticks(2);

    // Reset state
    chk("rst_ack", {bus.p2_ack, bus.p1_ack, bus.p0_ack}, 0);
    chk("rst_rdata", {bus.p2_rdata, bus.p1_rdata, bus.p0_rdata}, 0);
    chk("rst_strobes", {bus.ram_rd, bus.ram_we}, 0);
    chk("rst_ram_addr", bus.ram_addr, 0);
    chk("rst_ram_di", bus.ram_di, 0);
    chk("rst_cpu_hold", bus.cpu_hold, 0);
    reset = 1'b0;
    tick();

    // CPU read of 0x0123
    bus.p2_req = 1; bus.p2_we = 0; bus.p2_addr = 13'h0123;
    #1 chk("rd_cpu_hold", bus.cpu_hold, 1);
    tick();
    chk("rd_ram_rd", bus.ram_rd, 1);
    chk("rd_ram_we", bus.ram_we, 0);
    chk("rd_ram_addr", bus.ram_addr, 13'h0123);
    tick();
    chk("rd_strobe_off", bus.ram_rd, 0);
    chk("rd_ack_early", bus.p2_ack, 0);
    tick();
    chk("rd_ack", bus.p2_ack, 1);
    chk("rd_rdata", bus.p2_rdata, 8'h5A);
    chk("rd_hold_ack", bus.cpu_hold, 0);
    bus.p2_req = 0;
    tick();
    chk("rd_ack_pulse", bus.p2_ack, 0);
    chk("rd_rdata_held", bus.p2_rdata, 8'h5A);

    // Loader write 0x1FFF <= 0xC3
    bus.p1_req = 1; bus.p1_we = 1; bus.p1_addr = 13'h1FFF; bus.p1_wdata = 8'hC3;
    tick();
    chk("wr_ram_we", bus.ram_we, 1);
    chk("wr_ram_rd", bus.ram_rd, 0);
    chk("wr_ram_addr", bus.ram_addr, 13'h1FFF);
    chk("wr_ram_di", bus.ram_di, 8'hC3);
    tick();
    chk("wr_we_pulse", bus.ram_we, 0);
    chk("wr_addr_hold", bus.ram_addr, 13'h1FFF);
    tick();
    chk("wr_ack", bus.p1_ack, 1);
    chk("wr_rdata_unch", bus.p1_rdata, 8'h00);
    bus.p1_req = 0; bus.p1_we = 0;
    tick();
    chk("wr_mem", mem[13'h1FFF], 8'hC3);

    // Contention p0 vs p2
    bus.p0_req = 1; bus.p0_we = 0; bus.p0_addr = 13'h0010;
    bus.p2_req = 1; bus.p2_we = 0; bus.p2_addr = 13'h0020;
    ticks(3);
    chk("ct_p0_ack", bus.p0_ack, 1);
    chk("ct_p2_not_yet", bus.p2_ack, 0);
    chk("ct_p0_rdata", bus.p0_rdata, 8'h11);
    bus.p0_req = 0;
    tick();
    chk("ct_p2_issue", bus.ram_addr, 13'h0020);
    ticks(2);
    chk("ct_p2_ack", bus.p2_ack, 1);
    chk("ct_p2_rdata", bus.p2_rdata, 8'h22);
    bus.p2_req = 0;
    tick();

    // Starvation: p0/p1 keep requesting while p2 waits
    bus.p0_req = 1; bus.p0_addr = 13'h0010;
    bus.p1_req = 1; bus.p1_we = 0; bus.p1_addr = 13'h0030;
    bus.p2_req = 1; bus.p2_addr = 13'h0123;
    nc_acks = 0; p2_early = 0;
    for (int i = 1; i <= 15; i++) begin
      tick();
      if (i < 15) begin
        if (bus.p0_ack || bus.p1_ack) nc_acks++;
        if (bus.p2_ack) p2_early++;
      end
      if (i == 13) chk("sv_p2_issue", bus.ram_addr, 13'h0123);
    end
    chk("sv_p2_early", p2_early, 0);
    chk("sv_nc_grants", nc_acks, 4);
    chk("sv_p2_ack", bus.p2_ack, 1);
    chk("sv_p1_rdata", bus.p1_rdata, 8'h33);
    bus.p0_req = 0; bus.p1_req = 0; bus.p2_req = 0;
    tick();

    // Loader-exclusive mode
    bus.spi_load = 1;
    bus.p1_req = 1; bus.p1_we = 0; bus.p1_addr = 13'h0010;
    bus.p2_req = 1; bus.p2_we = 0; bus.p2_addr = 13'h0020;
    #1 chk("ld_cpu_hold", bus.cpu_hold, 1);
    ticks(3);
    chk("ld_p1_ack", bus.p1_ack, 1);
    chk("ld_p2_wait", bus.p2_ack, 0);
    chk("ld_p1_rdata", bus.p1_rdata, 8'h11);
    bus.p1_req = 0;
    tick();
    chk("ld_no_access", bus.ram_rd, 0);
    bus.spi_load = 0;
    #1 chk("ld_hold_cpu", bus.cpu_hold, 1);
    tick();
    chk("ld_p2_issue", bus.ram_rd, 1);
    chk("ld_p2_addr", bus.ram_addr, 13'h0020);
    ticks(2);
    chk("ld_p2_ack", bus.p2_ack, 1);
    bus.p2_req = 0;
    tick();

    // Reset arriving in the ISSUE cycle of a p0 write
    bus.p0_req = 1; bus.p0_we = 1; bus.p0_addr = 13'h0055; bus.p0_wdata = 8'hAA;
    tick();
    reset = 1;
    #1 chk("rs_we_gated", bus.ram_we, 0);
    bus.p0_req = 0;
    tick();
    reset = 0;
    chk("rs_no_ack", {bus.p2_ack, bus.p1_ack, bus.p0_ack}, 0);
    chk("rs_strobes", {bus.ram_rd, bus.ram_we}, 0);
    chk("rs_ram_addr", bus.ram_addr, 0);
    chk("rs_ram_di", bus.ram_di, 0);
    chk("rs_rdata", {bus.p2_rdata, bus.p1_rdata, bus.p0_rdata}, 0);
    ticks(3);
    chk("rs_no_late_ack", bus.p0_ack, 0);
    chk("rs_mem_untouched", mem[13'h0055], 8'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
